// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared constants for the instruction-memory access controller.
// Rev 1.0 - initial release
`default_nettype none

package imem_ctrl_pkg;

  localparam logic [1:0]  ST_BOOT          = 2'b00;
  localparam logic [1:0]  ST_RUN           = 2'b01;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0020;
  localparam int          WORD_COUNT_W     = 16;

  function automatic logic [WORD_COUNT_W-1:0] sat_inc(input logic [WORD_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_starve_counter.sv
// imem_starve_counter: saturating count of consecutive denied-load cycles.
// Rev 1.0 - initial release
`default_nettype none

module imem_starve_counter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == c_MAX);

endmodule

`default_nettype wire

// File: rtl/imem_access_controller.sv
// imem_access_controller: boot loader / fetch arbiter for a single-port instruction memory.
// Rev 1.0 - initial release
`default_nettype none

module imem_access_controller
  import imem_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    load_done,
  input  logic                    fetch_req,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic                    fetch_stall,
  output logic                    fetch_valid,
  output logic [DATA_W-1:0]       fetch_instr,
  output logic                    pc_start_valid,
  output logic [ADDR_W-1:0]       pc_start,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [WORD_COUNT_W-1:0] word_count
);

  logic [1:0]              r_state;
  logic                    r_fetch_valid;
  logic [DATA_W-1:0]       r_fetch_instr;
  logic                    r_pc_start_valid;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [DATA_W-1:0]       r_mem_wdata;
  logic [WORD_COUNT_W-1:0] r_word_count;

  logic w_load_grant;
  logic w_fetch_grant;
  logic w_at_max;
  logic w_boot;

  assign w_boot = (r_state == ST_BOOT);

  // Grants are gated by rst so nothing reaches the memory while reset is held.
  always_comb begin
    w_load_grant  = 1'b0;
    w_fetch_grant = 1'b0;
    if (rst) begin
      if (w_boot) begin
        w_load_grant = load_valid;
      end else if (r_state == ST_RUN) begin
        w_load_grant  = load_valid && (!fetch_req || w_at_max);
        w_fetch_grant = fetch_req && !w_load_grant;
      end
    end
  end

  imem_starve_counter #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (4)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (load_valid && !w_load_grant),
    .i_clr    (!load_valid || w_load_grant),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_BOOT;
      r_fetch_valid    <= 1'b0;
      r_fetch_instr    <= '0;
      r_pc_start_valid <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_word_count     <= '0;
    end else begin
      r_fetch_valid    <= w_fetch_grant;
      r_pc_start_valid <= w_boot && load_done;
      if (w_boot && load_done) begin
        r_state <= ST_RUN;
      end else if (!w_boot && (r_state != ST_RUN)) begin
        r_state <= ST_BOOT;
      end
      if (w_fetch_grant) begin
        r_fetch_instr <= mem_rdata;
        r_mem_addr    <= fetch_addr;
      end
      if (w_load_grant) begin
        r_mem_addr   <= load_addr;
        r_mem_wdata  <= load_data;
        r_word_count <= sat_inc(r_word_count);
      end
    end
  end

  assign load_ready     = w_load_grant;
  assign fetch_stall    = !w_fetch_grant;
  assign mem_we         = w_load_grant;
  assign mem_addr       = w_load_grant ? load_addr : (w_fetch_grant ? fetch_addr : r_mem_addr);
  assign mem_wdata      = w_load_grant ? load_data : r_mem_wdata;
  assign fetch_valid    = r_fetch_valid;
  assign fetch_instr    = r_fetch_instr;
  assign pc_start_valid = r_pc_start_valid;
  assign pc_start       = RESET_PC;
  assign word_count     = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_imem_access_controller.sv
// tb_imem_access_controller: directed self-checking bench with a behavioural memory.
// Rev 1.0 - initial release
`default_nettype none

module tb_imem_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_ready, load_done;
  logic [31:0] load_addr, load_data;
  logic        fetch_req, fetch_stall, fetch_valid;
  logic [31:0] fetch_addr, fetch_instr;
  logic        pc_start_valid;
  logic [31:0] pc_start, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A1 = 32'hFF55_4555, D1 = 32'h5D45_75DF;
  localparam logic [31:0] A2 = 32'hFC55_7555, D2 = 32'h5D45_75DC;
  localparam logic [31:0] A3 = 32'hFF55_4577, D3 = 32'h5D45_75D0;
  localparam logic [31:0] A4 = 32'h1000_0100, D4 = 32'hCAFE_0004;
  localparam logic [31:0] A5 = 32'h2000_0200, D5 = 32'hBEEF_0005;
  localparam logic [31:0] A6 = 32'h3000_0300, D6 = 32'h0000_6666;

  // Memory model indexed by the low 16 address bits (test addresses are distinct there).
  logic [31:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr[15:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[15:0]] <= mem_wdata;

  always #5 clk = ~clk;

  imem_access_controller #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .RESET_PC   (32'h0000_0020),
    .STARVE_MAX (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_done      (load_done),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_stall    (fetch_stall),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .pc_start_valid (pc_start_valid),
    .pc_start       (pc_start),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata),
    .word_count     (word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a, input logic [31:0] d);
    load_valid = v;
    load_addr  = a;
    load_data  = d;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    rst = 1'b0; load_done = 1'b0; fetch_req = 1'b1; fetch_addr = A1;
    set_load(1'b1, A1, D1);
    #3;
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_fetch_instr", fetch_instr, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    chk("rst_pc_start_valid", {31'd0, pc_start_valid}, 32'd0);
    chk("rst_pc_start", pc_start, 32'h20);
    tick();
    rst = 1'b1;
    #1;

    // Boot load of three words
    chk("boot1_ready", {31'd0, load_ready}, 32'd1);
    chk("boot1_we", {31'd0, mem_we}, 32'd1);
    chk("boot1_addr", mem_addr, A1);
    chk("boot1_wdata", mem_wdata, D1);
    chk("boot1_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    set_load(1'b1, A2, D2);
    #1 chk("boot2_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    set_load(1'b1, A3, D3);
    #1 chk("boot3_addr", mem_addr, A3);
    tick();
    set_load(1'b0, A3, D3);
    fetch_req = 1'b0;
    #1 chk("boot_idle_we", {31'd0, mem_we}, 32'd0);
    chk("boot_idle_addr_hold", mem_addr, A3);
    chk("boot_word_count", {16'd0, word_count}, 32'd3);
    load_done = 1'b1;
    #1 chk("boot_done_stall", {31'd0, fetch_stall}, 32'd1);
    tick();

    // First RUN cycle: pulse and fetch of A1
    load_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = A1;
    #1 chk("run_pcsv_hi", {31'd0, pc_start_valid}, 32'd1);
    chk("run_pc_start", pc_start, 32'h20);
    chk("f1_stall", {31'd0, fetch_stall}, 32'd0);
    chk("f1_we", {31'd0, mem_we}, 32'd0);
    chk("f1_addr", mem_addr, A1);
    tick();
    fetch_addr = A2;
    #1 chk("f1_valid", {31'd0, fetch_valid}, 32'd1);
    chk("f1_instr", fetch_instr, D1);
    chk("run_pcsv_lo", {31'd0, pc_start_valid}, 32'd0);
    tick();
    fetch_addr = A3;
    #1 chk("f2_instr", fetch_instr, D2);
    tick();
    fetch_req = 1'b0;
    #1 chk("f3_valid", {31'd0, fetch_valid}, 32'd1);
    chk("f3_instr", fetch_instr, D3);
    tick();
    #1 chk("idle_valid", {31'd0, fetch_valid}, 32'd0);
    chk("idle_instr_hold", fetch_instr, D3);

    // Starvation: continuous fetch with a held late load
    fetch_req = 1'b1; fetch_addr = A1;
    set_load(1'b1, A4, D4);
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("starve_deny%0d", i), {31'd0, load_ready}, 32'd0);
      chk($sformatf("starve_fetch%0d", i), {31'd0, fetch_stall}, 32'd0);
      tick();
    end
    #1 chk("starve_grant", {31'd0, load_ready}, 32'd1);
    chk("starve_stall", {31'd0, fetch_stall}, 32'd1);
    chk("starve_we", {31'd0, mem_we}, 32'd1);
    chk("starve_addr", mem_addr, A4);
    tick();
    #1 chk("starve_cleared", {31'd0, load_ready}, 32'd0);
    chk("starve_wc", {16'd0, word_count}, 32'd4);
    chk("starve_no_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    tick();

    // Idle-fetch late load is granted at once
    fetch_req = 1'b0;
    set_load(1'b1, A6, D6);
    #1 chk("late_load_ready", {31'd0, load_ready}, 32'd1);
    tick();
    set_load(1'b0, A6, D6);
    fetch_req = 1'b1; fetch_addr = A4;
    load_done = 1'b1;
    tick();
    fetch_addr = A6;
    #1 chk("late_f4_instr", fetch_instr, D4);
    chk("run_done_no_pcsv", {31'd0, pc_start_valid}, 32'd0);
    chk("run_done_no_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    load_done = 1'b0;
    #1 chk("late_f6_instr", fetch_instr, D6);
    chk("late_wc", {16'd0, word_count}, 32'd5);

    // Reset mid-fetch
    rst = 1'b0;
    #1 chk("midrst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("midrst_wc", {16'd0, word_count}, 32'd0);
    chk("midrst_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    rst = 1'b1;
    #1 chk("reboot_stall", {31'd0, fetch_stall}, 32'd1);
    set_load(1'b1, A5, D5);
    load_done = 1'b1;
    #1 chk("done_load_ready", {31'd0, load_ready}, 32'd1);
    chk("done_load_we", {31'd0, mem_we}, 32'd1);
    tick();
    set_load(1'b0, A5, D5);
    load_done = 1'b0;
    fetch_addr = A5;
    #1 chk("done_wc", {16'd0, word_count}, 32'd1);
    chk("done_pcsv", {31'd0, pc_start_valid}, 32'd1);
    chk("done_run_fetch", {31'd0, fetch_stall}, 32'd0);
    tick();
    fetch_addr = A2;
    #1 chk("f5_instr", fetch_instr, D5);
    tick();
    fetch_req = 1'b0;
    #1 chk("refetch_old", fetch_instr, D2);
    chk("refetch_valid", {31'd0, fetch_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
